// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 16-bit five-stage pipeline. It owns the PC
//   and fetches one instruction at a time from instruction memory over a
//   request/grant/response handshake with variable latency. It feeds the
//   IF/ID register (instruction, PC+step, valid, flush, hold) and handles
//   branch redirects, back-pressure from the hazard unit, and HALT.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   stall_in          IF/ID may not consume the output slot this cycle
//   redirect_in/_pc   one-cycle taken-branch pulse and its target PC
//   halt_in           decode saw HALT; stop fetching until reset
//   imem_req/_addr    fetch request and its address (current PC)
//   imem_gnt          memory accepted the request this cycle
//   imem_rvalid/_rdata one-cycle response carrying the instruction word
//   instr_out/pc_out  instruction held for IF/ID and its fetch address + step
//   valid_out         instr_out/pc_out hold a valid instruction
//   flush_out         registered pulse the cycle after an accepted redirect
//   stop_pc_out       IF/ID should hold its contents (!valid_out | stall_in)
//   halt_out          the unit has stopped fetching
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned PC_STEP   = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        flush_out,
  output logic        stop_pc_out,
  output logic        halt_out
);

  localparam logic [15:0] STEP = 16'(PC_STEP);

  // FETCH : may issue a request
  // WAIT  : one request outstanding, waiting for its response
  // HOLD  : response parked in the skid register behind a stalled slot
  // DRAIN : halting, but the outstanding response still has to be swallowed
  // HALTED: idle until reset
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;

  logic [15:0] pc_q, pc_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic        squash_q, squash_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] out_instr_q, out_instr_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;

  logic        active;
  logic        slot_free;
  logic        req;
  logic        fire;
  logic        halting;
  logic        redirecting;
  logic        resp_live;

  // -------------------------------------------------------------------------
  // Shared decode of the current cycle
  // -------------------------------------------------------------------------
  always_comb begin
    active      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_HOLD);
    // The slot can take a new instruction if empty or drained on this edge.
    slot_free   = !valid_q || !stall_in;
    // rst gates the request so nothing is presented while reset is held.
    req         = rst && (state_q == S_FETCH) && slot_free;
    fire        = req && imem_gnt;
    // Halt beats redirect; neither matters once the unit is draining/halted.
    halting     = active && halt_in;
    redirecting = active && redirect_in && !halt_in;
    // A response that should actually reach the output slot or skid.
    resp_live   = (state_q == S_WAIT) && imem_rvalid && !squash_q &&
                  !halting && !redirecting;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (halting) begin
          // A request granted this cycle will still answer; swallow it first.
          state_d = fire ? S_DRAIN : S_HALTED;
        end else if (fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (halting) begin
          state_d = imem_rvalid ? S_HALTED : S_DRAIN;
        end else if (imem_rvalid) begin
          if (squash_q || redirecting || slot_free) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (halting) begin
          state_d = S_HALTED;
        end else if (redirecting || !stall_in) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req    = req;
    imem_addr   = pc_q;
    valid_out   = valid_q;
    instr_out   = valid_q ? out_instr_q : NOP_INSTR;
    pc_out      = out_pc_q;
    flush_out   = flush_q;
    stop_pc_out = !valid_q || stall_in;
    halt_out    = (state_q == S_HALTED);
  end

  // -------------------------------------------------------------------------
  // Datapath next values: PC, squash, skid, output slot
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    squash_d     = squash_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;

    // IF/ID takes the slot on this edge; refills below override.
    if (valid_q && !stall_in) begin
      valid_d = 1'b0;
    end

    if (fire) begin
      fetch_addr_d = pc_q;
      pc_d         = pc_q + STEP;
    end

    // Any response seen in WAIT retires the squash flag.
    if ((state_q == S_WAIT) && imem_rvalid) begin
      squash_d = 1'b0;
    end

    if (resp_live) begin
      if (slot_free) begin
        out_instr_d = imem_rdata;
        out_pc_d    = fetch_addr_q + STEP;
        valid_d     = 1'b1;
      end else begin
        skid_instr_d = imem_rdata;
        skid_pc_d    = fetch_addr_q + STEP;
      end
    end

    if ((state_q == S_HOLD) && !stall_in && !halting && !redirecting) begin
      out_instr_d = skid_instr_q;
      out_pc_d    = skid_pc_q;
      valid_d     = 1'b1;
    end

    if (redirecting) begin
      pc_d     = redirect_pc;
      flush_d  = 1'b1;
      valid_d  = 1'b0;
      // The request granted now, or still outstanding, belongs to the old path.
      squash_d = fire || ((state_q == S_WAIT) && !imem_rvalid);
    end

    if (halting) begin
      valid_d  = 1'b0;
      squash_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers: control/state with reset, pure data without
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= 16'h0000;
      out_pc_q     <= 16'h0000;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_pc_q     <= out_pc_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    fetch_addr_q <= fetch_addr_d;
    out_instr_q  <= out_instr_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_in = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        flush_out;
  logic        stop_pc_out;
  logic        halt_out;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .PC_STEP  (2),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .redirect_in(redirect_in),
    .redirect_pc(redirect_pc),
    .halt_in    (halt_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out),
    .flush_out  (flush_out),
    .stop_pc_out(stop_pc_out),
    .halt_out   (halt_out)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0000 -> A001, 0002 -> A002, ...
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA001 + {1'b0, a[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs and memory model state ----------------
  logic        rst_next = 1'b0;
  int          stall_pct = 0, redir_pct = 0, halt_pct = 0, gnt_pct = 100;
  int          lat_min = 0, lat_max = 0;
  logic        redir_fixed = 1'b0;
  logic [15:0] fixed_target = 16'h0040;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          pend_lat = 0;
  logic        last_gnt = 1'b0;

  function automatic logic [15:0] pick_target();
    case ($urandom % 4)
      0:       return 16'h0040;
      1:       return 16'hFFFC;
      default: return 16'($urandom) & 16'hFFFE;
    endcase
  endfunction

  // One clock of stimulus: inputs change at the falling edge, grant after req settles.
  task automatic cycle();
    @(negedge clk);
    rst = rst_next;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'($urandom);
    if (pend) begin
      if (pend_lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_lat--;
      end
    end
    stall_in    = (int'($urandom % 100) < stall_pct);
    redirect_in = rst && (int'($urandom % 100) < redir_pct);
    redirect_pc = redir_fixed ? fixed_target : pick_target();
    halt_in     = rst && (int'($urandom % 100) < halt_pct);
    #1;
    imem_gnt = 1'b0;
    if (imem_req && !pend && (int'($urandom % 100) < gnt_pct)) begin
      imem_gnt  = 1'b1;
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_lat  = int'($urandom_range(lat_max, lat_min));
    end
    last_gnt = imem_gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_gnt && n < 50);
    chk(name, last_gnt, 1'b1);
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_pc = RST_PC;
  logic        halted_m = 1'b0;
  logic        exp_flush = 1'b0;
  int          cyc = 0;
  int          cons_cnt = 0;
  int          first_gnt_cyc = -1;
  int          first_vld_cyc = -1;

  // Samples one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (!rst) begin
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_instr", instr_out, 16'h0000);
      chk("rst_pc_out", pc_out, 16'h0000);
      chk("rst_flush", flush_out, 1'b0);
      chk("rst_halt", halt_out, 1'b0);
      chk("rst_stop_pc", stop_pc_out, 1'b1);
      exp_q.delete();
      exp_pc        = RST_PC;
      halted_m      = 1'b0;
      exp_flush     = 1'b0;
      first_gnt_cyc = -1;
      first_vld_cyc = -1;
    end else begin
      chk("flush", flush_out, exp_flush);
      if (halted_m) begin
        chk("halted_req", imem_req, 1'b0);
        chk("halted_valid", valid_out, 1'b0);
        chk("halted_stop_pc", stop_pc_out, 1'b1);
      end else begin
        chk("halt_early", halt_out, 1'b0);
        if (valid_out) begin
          if (first_vld_cyc < 0) first_vld_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", valid_out, 1'b0);
          end else begin
            chk("instr", instr_out, exp_q[0].instr);
            chk("pc_out", pc_out, exp_q[0].pc);
            if (!stall_in) begin
              void'(exp_q.pop_front());
              cons_cnt++;
            end
          end
        end
        if (imem_req && imem_gnt) begin
          if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
          chk("imem_addr", imem_addr, exp_pc);
          if (!halt_in && !redirect_in) begin
            exp_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc + 16'd2});
          end
          exp_pc = exp_pc + 16'd2;
        end
      end
      exp_flush = redirect_in && !halt_in && !halted_m;
      if (!halted_m && halt_in) begin
        halted_m = 1'b1;
        exp_q.delete();
      end else if (!halted_m && redirect_in) begin
        exp_pc = redirect_pc;
        exp_q.delete();
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;

    // Reset, then straight-line fetch with 1-cycle memory.
    rst_next = 1'b0;
    run(3);
    rst_next = 1'b1;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    stall_pct = 0; redir_pct = 0; halt_pct = 0;
    base = cons_cnt;
    run(40);
    chk("seq_latency", first_vld_cyc - first_gnt_cyc, 2);
    chk("seq_throughput_ok", (cons_cnt - base) >= 15, 1'b1);

    // Stall bursts of five cycles.
    lat_min = 0; lat_max = 1;
    base = cons_cnt;
    for (int b = 0; b < 10; b++) begin
      stall_pct = 0;
      run(2 + b % 3);
      stall_pct = 100;
      run(5);
    end
    stall_pct = 0;
    run(10);
    chk("stall_progress", (cons_cnt - base) >= 10, 1'b1);

    // Redirect to 0040 while a request is outstanding.
    lat_min = 2; lat_max = 2;
    wait_gnt("redir_gnt_timeout");
    redir_fixed = 1'b1; fixed_target = 16'h0040; redir_pct = 100;
    cycle();
    redir_pct = 0; redir_fixed = 1'b0;
    lat_min = 0; lat_max = 0;
    run(20);

    // Randomized mix.
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    stall_pct = 30; redir_pct = 5;
    base = cons_cnt;
    run(2000);
    chk("random_progress", (cons_cnt - base) >= 100, 1'b1);
    stall_pct = 0; redir_pct = 0; gnt_pct = 100;

    // Reset while a response is outstanding; it arrives after release.
    lat_min = 3; lat_max = 3;
    wait_gnt("rst_gnt_timeout");
    rst_next = 1'b0;
    run(2);
    rst_next = 1'b1;
    lat_min = 0; lat_max = 0;
    base = cons_cnt;
    run(20);
    chk("post_rst_progress", (cons_cnt - base) >= 5, 1'b1);

    // Halt together with a redirect while waiting on memory.
    lat_min = 2; lat_max = 2;
    wait_gnt("halt_gnt_timeout");
    halt_pct = 100; redir_pct = 100;
    cycle();
    halt_pct = 0; redir_pct = 0;
    run(25);
    chk("halt_out", halt_out, 1'b1);
    chk("halt_req", imem_req, 1'b0);

    // Fresh start with occasional halts mixed into random traffic.
    rst_next = 1'b0;
    run(2);
    rst_next = 1'b1;
    gnt_pct = 70; lat_min = 0; lat_max = 3;
    stall_pct = 25; redir_pct = 4; halt_pct = 1;
    run(500);
    halt_pct = 0; redir_pct = 0; stall_pct = 0;
    rst_next = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit 5-stage pipeline; the producer side of the IF/ID register interface.
- Owns the PC and issues requests to instruction memory over a variable-latency request/grant/response handshake.
- Presents fetched instruction, PC+2, flush and hold indications to IF/ID.
- Handles branch redirect, pipeline stall back-pressure and HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, sequential PC increment (byte-addressed, 16-bit instructions).
NOP_INSTR, 16'h0000, value driven on instr_out when no valid instruction is held.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stall_in  in  1  hazard unit: IF/ID must not consume this cycle.
redirect_in  in  1  one-cycle pulse: taken branch/jump resolved.
redirect_pc  in  16  target PC, valid with redirect_in.
halt_in  in  1  decode saw HALT opcode; stop fetching.
imem_req  out  1  fetch request valid.
imem_addr  out  16  fetch address, equals current PC while imem_req=1.
imem_gnt  in  1  memory accepted request this cycle.
imem_rvalid  in  1  response data valid (one cycle, >=1 cycle after gnt).
imem_rdata  in  16  instruction word.
instr_out  out  16  instruction presented to IF/ID.
pc_out  out  16  fetch address of instr_out + PC_STEP.
valid_out  out  1  instr_out/pc_out hold a valid instruction.
flush_out  out  1  registered one-cycle pulse the cycle after a redirect.
stop_pc_out  out  1  combinational: !valid_out | stall_in (IF/ID holds its current contents).
halt_out  out  1  fetch unit halted.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0 during reset; valid_out=0, instr_out=NOP_INSTR, pc_out=0, flush_out=0, halt_out=0.
  - Squash flag and skid register cleared. Any in-flight response after reset release is ignored.
- States:
  - FETCH: imem_req=1 only if the output slot is free or being consumed (!valid_out | !stall_in). On imem_gnt: latch fetch_addr=pc, pc<=pc+PC_STEP (16-bit wrap, FFFE->0000), go to WAIT.
  - WAIT: imem_req=0; at most one outstanding request. On imem_rvalid:
    - if squash: discard, clear squash, go to FETCH.
    - else if slot free or consumed this cycle: load instr_out=rdata, pc_out=fetch_addr+PC_STEP, valid_out=1, go to FETCH.
    - else: store in skid register, go to HOLD.
  - HOLD: when stall_in=0 (slot consumed), move skid into output slot next edge, go to FETCH.
  - HALTED: imem_req=0, halt_out=1, valid_out=0. Exit only by reset.
- Consumption: the output slot is consumed on any edge with valid_out=1 & stall_in=0. valid_out drops to 0 unless refilled on the same edge. instr_out/pc_out are stable while valid_out & stall_in.
- Sequential latency: a grant in cycle N with rvalid in cycle N+1 gives valid_out=1 in N+2. Back-to-back issue gives a one-instruction-per-2-cycle minimum (single outstanding request).
- Redirect (redirect_in=1), takes priority over stall:
  - pc<=redirect_pc; flush_out=1 for exactly the next cycle.
  - valid_out<=0; the skid register is dropped (HOLD->FETCH).
  - If in WAIT, or FETCH with imem_gnt the same cycle, set squash so that response is discarded.
  - The next request is issued at redirect_pc; back-to-back redirects: the last one wins.
- Halt (halt_in=1):
  - valid_out<=0, imem_req deasserts next cycle.
  - From WAIT, or FETCH with gnt: enter an internal drain, discard the response, then go to HALTED. Otherwise go to HALTED directly.
  - halt_in and redirect_in in the same cycle: halt wins, no flush_out.
- stall_in alone never alters pc or state except blocking new requests and consumption.

Test Plan:
- Reset release, memory with 1-cycle latency returning 16'hA001,16'hA002,… -> imem_addr 0000,0002,0004; instr_out A001 with pc_out 0002, then A002 with pc_out 0004.
- stall_in held 5 cycles while a response arrives -> instr_out/pc_out frozen, HOLD entered, no new imem_req. After release: skid instruction presented next cycle, then fetch resumes at the correct sequential PC.
- redirect_in with redirect_pc=16'h0040 while in WAIT -> the old response is discarded, flush_out=1 for 1 cycle, next imem_addr=0040, next valid instr has pc_out=0042.
- PC wrap: RESET_PC=16'hFFFE -> first pc_out=0000, second imem_addr=0000.
- halt_in during WAIT -> the response is dropped, halt_out=1, imem_req stays 0 for 20 cycles. A redirect_in in the same cycle as halt_in produces no flush_out.
- rst asserted in WAIT, a stale rvalid arrives after release -> ignored; first valid instruction is from address RESET_PC.
